// File: rtl/uart_rx_pkg.sv
// Shared constants, FSM state encodings and parity helper for the 16x-oversampled UART receiver.
package uart_rx_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 7;
   localparam int W_BITCNT   = 3;
   localparam int W_STATE    = 3;

   typedef logic [W_STATE-1:0] state_t;

   localparam state_t IDLE   = 3'd0;
   localparam state_t START  = 3'd1;
   localparam state_t DATA   = 3'd2;
   localparam state_t PARITY = 3'd3;
   localparam state_t STOP   = 3'd4;

   // Even parity holds when data bits plus parity bit XOR to zero.
   function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
      return ~(^data ^ par);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: counts down from div-1 and emits tick at zero; clr restarts the phase.
module uart_baud_tick #(
   parameter int W_DIV = 16
) (
   input  logic             clk_sys,
   input  logic             rst_sys,
   input  logic             clr,
   input  logic [W_DIV-1:0] div,
   output logic             tick
);

   logic [W_DIV-1:0] cnt;
   logic [W_DIV-1:0] reload;

   // div of 0 behaves as 1, so both reload to zero and tick every cycle.
   assign reload = (div == '0) ? '0 : div - W_DIV'(1);
   assign tick   = (cnt == '0);

   always_ff @(posedge clk_sys) begin
      if (rst_sys || clr) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= reload;
      end else begin
         cnt <= cnt - W_DIV'(1);
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// 8-bit UART receiver, 16x oversampled, valid/ready output with error pulses.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err output; default is 8N1.
module uart_rx_core
   import uart_rx_pkg::*;
#(
   parameter int W_DIV      = 16,
   parameter int OVERSAMPLE = 16
) (
   input  logic             clk_sys,
   input  logic             rst_sys,
   input  logic             en,
   input  logic [W_DIV-1:0] div,
   input  logic             rx,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             framing_err,
   output logic             overrun_err
`ifdef UART_RX_PARITY_EN
   , output logic           parity_err
`endif
);

   localparam int              W_OS   = $clog2(OVERSAMPLE);
   localparam logic [W_OS-1:0] OS_MID = W_OS'(MID_SAMPLE);

   logic                rx_meta;
   logic                rx_s;
   logic                rx_s_prev;
   state_t              state;
   logic [W_OS-1:0]     os;
   logic [W_BITCNT-1:0] bit_cnt;
   logic [7:0]          shreg;
   logic                tick;
   logic                mid;
   logic                fall;
   logic                clr_div;
   logic                byte_done;
   logic                frame_bad;
`ifdef UART_RX_PARITY_EN
   logic                par_bit;
   logic                par_bad;
`endif

   always_ff @(posedge clk_sys) begin
      // NOTE: sequential state always uses <= so every flop samples pre-edge values.
      if (rst_sys) begin
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         rx_s_prev <= 1'b1;
      end else begin
         rx_meta   <= rx;
         rx_s      <= rx_meta;
         rx_s_prev <= rx_s;
      end
   end

   assign fall    = rx_s_prev & ~rx_s;
   assign mid     = tick & (os == OS_MID);
   assign clr_div = ~en | ((state == IDLE) & fall);

   uart_baud_tick #(.W_DIV(W_DIV)) u_baud_tick (
      .clk_sys (clk_sys),
      .rst_sys (rst_sys),
      .clr     (clr_div),
      .div     (div),
      .tick    (tick)
   );

   always_ff @(posedge clk_sys) begin
      if (rst_sys || !en) begin
         state   <= IDLE;
         os      <= '0;
         bit_cnt <= '0;
      end else begin
         if (tick) os <= os + W_OS'(1);
         case (state)
            IDLE: begin
               if (fall) begin
                  state <= START;
                  os    <= '0;
               end
            end
            START: begin
               if (mid) begin
                  if (rx_s) begin
                     state <= IDLE;
                  end else begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
            end
            DATA: begin
               if (mid) begin
                  if (bit_cnt == {W_BITCNT{1'b1}}) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + W_BITCNT'(1);
                  end
               end
            end
            PARITY: begin
               if (mid) state <= STOP;
            end
            STOP: begin
               if (mid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: the shift register has no reset; every bit is overwritten before a byte can complete.
   always_ff @(posedge clk_sys) begin
      if (state == DATA && mid) shreg <= {rx_s, shreg[7:1]};
`ifdef UART_RX_PARITY_EN
      if (state == PARITY && mid) par_bit <= rx_s;
`endif
   end

   always_comb begin
      // NOTE: defaults first so no path through this block infers a latch.
      byte_done = 1'b0;
      frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   = 1'b0;
`endif
      if (en && state == STOP && mid) begin
         if (!rx_s) begin
            frame_bad = 1'b1;
         end else begin
            byte_done = 1'b1;
`ifdef UART_RX_PARITY_EN
            if (!even_parity_ok(shreg, par_bit)) begin
               byte_done = 1'b0;
               par_bad   = 1'b1;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst_sys) begin
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         framing_err <= 1'b0;
         overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err  <= 1'b0;
`endif
      end else begin
         framing_err <= frame_bad;
         overrun_err <= byte_done & rx_valid & ~rx_ready;
`ifdef UART_RX_PARITY_EN
         parity_err  <= par_bad;
`endif
         // A byte may land in the same cycle the held one is consumed.
         if (byte_done && (!rx_valid || rx_ready)) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
